// File: rtl/uart_rx_deserializer_if.sv
// Byte output channel of the UART receiver.
//   rx_data  : received byte, stable while rx_valid=1
//   rx_valid : rx_data holds an unconsumed byte
//   rx_ready : consumer accepts; transfer on a CLK edge with rx_valid && rx_ready
// master = receiver (byte source), slave = byte consumer.
interface uart_rx_deserializer_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: synchronizes the raw serial line, finds the start bit,
// samples each bit at its mid-point and hands good bytes to a one-entry
// valid/ready output buffer. Sticky framing-error and overrun flags.
// Ports:
//   CLK, RST    : clock, synchronous active-high reset
//   serial_in   : asynchronous serial line, idle high
//   rx          : byte channel (rx_data / rx_valid / rx_ready), master side
//   frame_err   : sticky, a stop bit was sampled low
//   overrun     : sticky, a byte completed while the buffer was still full
//   err_clear   : clears both sticky flags (a same-cycle error event wins)
//   busy        : receiver is inside a frame
module uart_rx_deserializer #(
   parameter int CLKS_PER_BIT = 10416,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     serial_in,
   uart_rx_deserializer_if.master   rx,
   output logic                     frame_err,
   output logic                     overrun,
   input  logic                     err_clear,
   output logic                     busy
);

   localparam int            CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2:0]             bit_q, bit_d;
   logic [7:0]             shift_q, shift_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   armed_q, armed_d;
   logic                   pend_q, pend_d;
   logic [7:0]             data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   fe_q, fe_d;
   logic                   ov_q, ov_d;
   logic                   busy_q, busy_d;
   logic                   s_in;
   logic                   fe_ev, ov_ev;

   assign s_in = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      sync_d  = {sync_q[SYNC_STAGES-2:0], serial_in};
      armed_d = armed_q;
      pend_d  = 1'b0;
      data_d  = data_q;
      valid_d = valid_q;
      fe_ev   = 1'b0;
      ov_ev   = 1'b0;

      case (state_q)
         S_IDLE: begin
            // armed_q drops after a low stop bit so that the still-low line
            // is not mistaken for the next start bit.
            if (s_in) armed_d = 1'b1;
            if (!s_in && armed_q) begin
               state_d = S_START;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               state_d = s_in ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shift_d = {s_in, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               if (s_in) begin
                  pend_d = 1'b1;
               end else begin
                  fe_ev   = 1'b1;
                  armed_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Delivery happens the cycle after the stop sample; shift_q is not
      // touched again until the next frame's first data sample.
      if (pend_q) begin
         if (!valid_q || rx.rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ov_ev = 1'b1;
         end
      end else if (valid_q && rx.rx_ready) begin
         valid_d = 1'b0;
      end

      fe_d   = (fe_q & ~err_clear) | fe_ev;
      ov_d   = (ov_q & ~err_clear) | ov_ev;
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         sync_q  <= '1;
         armed_q <= 1'b1;
         pend_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         sync_q  <= sync_d;
         armed_q <= armed_d;
         pend_q  <= pend_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         fe_q    <= fe_d;
         ov_q    <= ov_d;
         busy_q  <= busy_d;
      end
   end

   assign rx.rx_data  = data_q;
   assign rx.rx_valid = valid_q;
   assign frame_err   = fe_q;
   assign overrun     = ov_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
module tb_uart_rx_deserializer;
   localparam int CPB = 16;
   // Edge offset (from the first edge that sees the start bit on the pin)
   // of the stop-bit sample: synchronizer + half bit + 9 full bits.
   localparam int STOP_S = 2 + CPB/2 + 9*CPB;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic serial_in = 1'b1;
   logic rx_ready = 1'b1;
   logic err_clear = 1'b0;
   logic frame_err, overrun, busy;

   uart_rx_deserializer_if rxif();
   assign rxif.rx_ready = rx_ready;

   uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
      .CLK(CLK), .RST(RST), .serial_in(serial_in), .rx(rxif),
      .frame_err(frame_err), .overrun(overrun), .err_clear(err_clear), .busy(busy));

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct { int at; logic [7:0] b; bit good; } ev_t;
   typedef struct { int lo; int hi; } win_t;
   ev_t  evq[$];
   win_t bq[$];

   int n_chk = 0, n_pass = 0, vcnt = 0;
   bit rand_mode = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", nm, act, exp, cyc);
   endtask

   // ---------------- reference model + per-cycle compare ----------------
   logic       m_valid, m_fe, m_ov, m_busy;
   logic [7:0] m_data, ab;
   bit         arr, fe_ev, ov_ev;
   logic       pr_rst = 1'b1, pr_rdy = 1'b1, pr_clr = 1'b0;
   ev_t        e;

   initial begin
      forever begin
         @(negedge CLK);
         // apply the edge that just happened, with the inputs it saw
         if (pr_rst) begin
            m_valid = 0; m_data = 0; m_fe = 0; m_ov = 0;
            evq.delete(); bq.delete();
         end else begin
            arr = 0; fe_ev = 0; ov_ev = 0; ab = 0;
            while (evq.size() > 0 && evq[0].at == cyc) begin
               e = evq.pop_front();
               if (e.good) begin arr = 1; ab = e.b; end
               else fe_ev = 1;
            end
            if (arr) begin
               if (!m_valid || pr_rdy) begin m_data = ab; m_valid = 1; end
               else ov_ev = 1;
            end else if (m_valid && pr_rdy) m_valid = 0;
            m_fe = (m_fe && !pr_clr) || fe_ev;
            m_ov = (m_ov && !pr_clr) || ov_ev;
         end
         while (bq.size() > 0 && bq[0].hi < cyc) void'(bq.pop_front());
         m_busy = (bq.size() > 0 && bq[0].lo <= cyc);
         if (cyc >= 1) begin
            chk("rx_valid",  {31'd0, rxif.rx_valid}, {31'd0, m_valid});
            chk("rx_data",   {24'd0, rxif.rx_data},  {24'd0, m_data});
            chk("frame_err", {31'd0, frame_err},     {31'd0, m_fe});
            chk("overrun",   {31'd0, overrun},       {31'd0, m_ov});
            chk("busy",      {31'd0, busy},          {31'd0, m_busy});
         end
         if (rxif.rx_valid === 1'b1) vcnt++;
         pr_rst = RST; pr_rdy = rx_ready; pr_clr = err_clear;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge CLK); #2;
      if (rand_mode) begin
         rx_ready  = 1'($urandom_range(0, 1));
         err_clear = ($urandom_range(0, 19) == 0);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin tick(); serial_in = 1'b1; end
   endtask

   task automatic send(input logic [7:0] b, input bit stop_ok, input int abort_at = -1);
      logic [9:0] fr;
      int f;
      win_t w;
      ev_t  ev;
      fr = {stop_ok, b, 1'b0};
      for (int i = 0; i < 10*CPB; i++) begin
         tick();
         if (i == abort_at) begin
            RST = 1'b1; serial_in = 1'b1;
            tick();
            RST = 1'b0;
            return;
         end
         serial_in = fr[i/CPB];
         if (i == 0) begin
            f = cyc + 1;
            w.lo = f + 2; w.hi = f + STOP_S - 1;
            bq.push_back(w);
            ev.at = stop_ok ? f + STOP_S + 1 : f + STOP_S;
            ev.b = b; ev.good = stop_ok;
            evq.push_back(ev);
         end
      end
   endtask

   task automatic glitch(input int len);
      int f;
      win_t w;
      for (int i = 0; i < len; i++) begin
         tick();
         serial_in = 1'b0;
         if (i == 0) begin
            f = cyc + 1;
            w.lo = f + 2; w.hi = f + 1 + CPB/2;
            bq.push_back(w);
         end
      end
      tick();
      serial_in = 1'b1;
   endtask

   int v0, r;

   initial begin
      repeat (3) tick();
      RST = 1'b0;
      tick();
      chk("reset_valid", {31'd0, rxif.rx_valid}, 32'd0);
      chk("reset_data",  {24'd0, rxif.rx_data},  32'd0);
      chk("reset_busy",  {31'd0, busy},          32'd0);
      idle(20);

      // single byte
      v0 = vcnt;
      send(8'hA5, 1);
      idle(5);
      chk("a5_data",  {24'd0, rxif.rx_data}, 32'hA5);
      chk("a5_pulse", vcnt - v0, 32'd1);
      chk("a5_ferr",  {31'd0, frame_err}, 32'd0);
      chk("a5_busy",  {31'd0, busy}, 32'd0);

      // back-to-back, no idle gap
      v0 = vcnt;
      send(8'h00, 1);
      send(8'hFF, 1);
      idle(5);
      chk("b2b_pulses", vcnt - v0, 32'd2);
      chk("b2b_data",   {24'd0, rxif.rx_data}, 32'hFF);

      // short low glitch
      v0 = vcnt;
      glitch(5);
      idle(20);
      chk("glitch_valid", vcnt - v0, 32'd0);
      chk("glitch_busy",  {31'd0, busy}, 32'd0);

      // low stop bit, clear, then a good byte
      v0 = vcnt;
      send(8'h3C, 0);
      idle(16);
      chk("fe_set",   {31'd0, frame_err}, 32'd1);
      chk("fe_novld", vcnt - v0, 32'd0);
      tick(); err_clear = 1'b1;
      tick(); err_clear = 1'b0;
      chk("fe_clear", {31'd0, frame_err}, 32'd0);
      send(8'h81, 1);
      idle(5);
      chk("after_fe_data", {24'd0, rxif.rx_data}, 32'h81);

      // overrun with consumer stalled
      rx_ready = 1'b0;
      send(8'h11, 1);
      send(8'h22, 1);
      idle(5);
      chk("ovr_valid", {31'd0, rxif.rx_valid}, 32'd1);
      chk("ovr_data",  {24'd0, rxif.rx_data},  32'h11);
      chk("ovr_flag",  {31'd0, overrun},       32'd1);
      tick(); rx_ready = 1'b1;
      tick(); rx_ready = 1'b0;
      chk("ovr_consumed", {31'd0, rxif.rx_valid}, 32'd0);
      idle(20);
      chk("ovr_no22", {24'd0, rxif.rx_data}, 32'h11);
      rx_ready = 1'b1;
      tick(); err_clear = 1'b1;
      tick(); err_clear = 1'b0;

      // reset in the middle of the data bits
      v0 = vcnt;
      send(8'h5A, 1, 4*CPB + 3);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_data", {24'd0, rxif.rx_data}, 32'd0);
      idle(20);
      chk("rst_nobyte", vcnt - v0, 32'd0);
      send(8'h5A, 1);
      idle(5);
      chk("rst_then_5a", {24'd0, rxif.rx_data}, 32'h5A);

      // randomized traffic
      rand_mode = 1;
      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            glitch($urandom_range(1, 6));
            idle($urandom_range(12, 20));
         end else if (r == 1) begin
            send(8'($urandom_range(0, 255)), 0);
            idle($urandom_range(2, 6));
         end else begin
            send(8'($urandom_range(0, 255)), 1);
            idle($urandom_range(0, 3));
         end
      end
      rand_mode = 0;
      rx_ready  = 1'b1;
      err_clear = 1'b0;
      idle(200);
      chk("final_idle", {31'd0, busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
